// File: rtl/tinyqv_registers.sv
// Nibble-serial RV32E register file: two combinational nibble read ports, one
// nibble write port, x0/x3/x4 hardwired, and x1[23:1] exposed for fast returns.
module tinyqv_registers #(
  parameter int XLEN          = 32,
  parameter int NUM_REGS      = 16,
  parameter int REG_ADDR_BITS = 4,
  localparam int CNT_BITS     = $clog2(XLEN / 4)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [CNT_BITS-1:0]      counter,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  input  logic [REG_ADDR_BITS-1:0] rd,
  output logic [3:0]               data_rs1,
  output logic [3:0]               data_rs2,
  input  logic [3:0]               data_rd,
  output logic [23:1]              return_addr
);

  localparam logic [XLEN-1:0] GP_VALUE = XLEN'(32'h0100_0400);
  localparam logic [XLEN-1:0] TP_VALUE = XLEN'(32'h0800_0000);

  logic [XLEN-1:0]       reg_view [NUM_REGS];
  logic [CNT_BITS+1:0]   nib_base;

  assign nib_base = {counter, 2'b00};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_view[gi] = '0;
      end else if (gi == 3) begin : g_gp
        assign reg_view[gi] = GP_VALUE;
      end else if (gi == 4) begin : g_tp
        assign reg_view[gi] = TP_VALUE;
      end else begin : g_rw
        logic [XLEN-1:0] reg_q;
        logic [XLEN-1:0] reg_d;

        always_comb begin
          reg_d = reg_q;
          if (wr_en && (rd == REG_ADDR_BITS'(gi))) begin
            reg_d[nib_base +: 4] = data_rd;
          end
        end

        // Contents are deliberately left unreset; rstn only gates the write,
        // so a write coinciding with reset is dropped and old nibbles survive.
        always_ff @(posedge clk) begin
          if (rstn) begin
            reg_q <= reg_d;
          end
        end

        assign reg_view[gi] = reg_q;
      end
    end
  endgenerate

  assign data_rs1    = reg_view[rs1][nib_base +: 4];
  assign data_rs2    = reg_view[rs2][nib_base +: 4];
  assign return_addr = reg_view[1][23:1];

endmodule

// File: tb/tb_tinyqv_registers.sv
// Self-checking bench for tinyqv_registers: table-driven write/readback vectors,
// hand-written corner sequences and a randomized run against a 16x32 model.
module tb_tinyqv_registers;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [2:0]  counter;
  logic [3:0]  rs1, rs2, rd;
  logic [3:0]  data_rs1, data_rs2, data_rd;
  logic [23:1] return_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: whole 32-bit registers plus a per-nibble "has been written" mask
  logic [31:0] mdl [16];
  logic [7:0]  vld [16];

  typedef struct {
    logic [3:0]  wr_reg;
    logic [31:0] wr_val;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  tinyqv_registers dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .counter(counter),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .data_rs1(data_rs1), .data_rs2(data_rs2), .data_rd(data_rd),
    .return_addr(return_addr)
  );

  function automatic bit is_fixed(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd3) || (r == 4'd4);
  endfunction

  function automatic logic [31:0] ref_reg(input logic [3:0] r);
    case (r)
      4'd0:    return 32'h0000_0000;
      4'd3:    return 32'h0100_0400;
      4'd4:    return 32'h0800_0000;
      default: return mdl[r];
    endcase
  endfunction

  function automatic logic [7:0] ref_vld(input logic [3:0] r);
    return is_fixed(r) ? 8'hFF : vld[r];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare the read ports and return_addr with the model, only where defined
  task automatic check_reads();
    logic [31:0] x1v, mask;
    #1;
    if (ref_vld(rs1)[counter]) chk("data_rs1", 32'(data_rs1), 32'(ref_reg(rs1)[counter*4 +: 4]));
    if (ref_vld(rs2)[counter]) chk("data_rs2", 32'(data_rs2), 32'(ref_reg(rs2)[counter*4 +: 4]));
    x1v  = ref_reg(4'd1);
    mask = '0;
    for (int n = 0; n < 6; n++) if (vld[1][n]) mask[n*4 +: 4] = 4'hF;
    mask = mask & 32'h00FF_FFFE;
    if (mask != 0) chk("return_addr", {8'h0, return_addr, 1'b0} & mask, x1v & mask);
  endtask

  // Advance one clock, updating the model with the write that lands at this edge
  task automatic cycle();
    @(posedge clk);
    if (rstn && wr_en && !is_fixed(rd)) begin
      mdl[rd][counter*4 +: 4] = data_rd;
      vld[rd][counter]        = 1'b1;
    end
    #1;
  endtask

  task automatic wr_nib(input logic [3:0] r, input int c, input logic [3:0] d);
    wr_en = 1'b1; rd = r; counter = 3'(c); data_rd = d;
    check_reads();
    cycle();
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
    for (int c = 0; c < 8; c++) wr_nib(r, c, v[c*4 +: 4]);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [31:0] v1, output logic [31:0] v2);
    wr_en = 1'b0; rs1 = r; rs2 = r;
    for (int c = 0; c < 8; c++) begin
      counter = 3'(c);
      #1;
      v1[c*4 +: 4] = data_rs1;
      v2[c*4 +: 4] = data_rs2;
    end
  endtask

  initial begin
    logic [31:0] r1, r2;

    for (int i = 0; i < 16; i++) begin mdl[i] = '0; vld[i] = '0; end
    vecs[0] = '{4'd5, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{4'd3, 32'hFFFF_FFFF, 32'h0100_0400};
    vecs[3] = '{4'd4, 32'hFFFF_FFFF, 32'h0800_0000};
    vecs[4] = '{4'd2, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[5] = '{4'd1, 32'h00AB_CDEF, 32'h00AB_CDEF};
    vecs[6] = '{4'd7, 32'hAAAA_AAAA, 32'hAAAA_AAAA};

    rstn = 1'b0; wr_en = 1'b0; counter = '0; rs1 = '0; rs2 = '0; rd = '0; data_rd = '0;

    // Constant registers are readable while in reset
    read_reg(4'd3, r1, r2); chk("reset_x3", r1, 32'h0100_0400);
    read_reg(4'd4, r1, r2); chk("reset_x4", r2, 32'h0800_0000);
    read_reg(4'd0, r1, r2); chk("reset_x0", r1, 32'h0);
    cycle(); cycle();
    rstn = 1'b1;
    cycle();

    // Table-driven write then readback through both ports
    for (int i = 0; i < 7; i++) begin
      write_reg(vecs[i].wr_reg, vecs[i].wr_val);
      read_reg(vecs[i].wr_reg, r1, r2);
      chk($sformatf("vec%0d_rs1", i), r1, vecs[i].exp_val);
      chk($sformatf("vec%0d_rs2", i), r2, vecs[i].exp_val);
    end

    chk("ra_full", 32'(return_addr), 32'h0055_E6F7);
    wr_nib(4'd1, 0, 4'h0);
    wr_en = 1'b0; #1;
    chk("ra_nib0", 32'(return_addr), 32'h0055_E6F0);

    // Read-during-write of the same register and nibble returns the old value
    for (int c = 0; c < 8; c++) begin
      wr_en = 1'b1; rd = 4'd7; rs1 = 4'd7; rs2 = 4'd7; counter = 3'(c); data_rd = 4'h5;
      #1;
      chk("rdw_rs1", 32'(data_rs1), 32'hA);
      chk("rdw_rs2", 32'(data_rs2), 32'hA);
      cycle();
    end
    read_reg(4'd7, r1, r2);
    chk("rdw_after", r1, 32'h5555_5555);

    // Reset pulsed mid-sequence: writes at reset edges are dropped
    write_reg(4'd6, 32'h0000_1234);
    wr_nib(4'd6, 4, 4'h9);
    rstn = 1'b0;
    #1;
    rs1 = 4'd3; counter = 3'd2; #1;
    chk("rst_mid_x3", 32'(data_rs1), 32'h4);
    for (int c = 0; c < 8; c++) begin
      wr_en = 1'b1; rd = (c % 2 == 0) ? 4'd2 : 4'd6; counter = 3'(c); data_rd = 4'h0;
      cycle();
    end
    wr_en = 1'b0; rstn = 1'b1;
    cycle();
    read_reg(4'd2, r1, r2); chk("rst_x2_kept", r1, 32'hCAFE_BABE);
    read_reg(4'd6, r1, r2); chk("rst_x6_kept", r1 & 32'h000F_FFFF, 32'h0009_1234);

    // Randomized regression against the model
    for (int i = 0; i < 3000; i++) begin
      rd      = 4'($urandom_range(0, 15));
      rs1     = 4'($urandom_range(0, 15));
      rs2     = 4'($urandom_range(0, 15));
      counter = 3'($urandom_range(0, 7));
      wr_en   = 1'($urandom_range(0, 1));
      data_rd = 4'($urandom);
      check_reads();
      cycle();
    end
    wr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
